// File: rtl/base_tcode_pkg.sv
// Thermometer-code helpers shared by the encoder pipe and the decoder-side checkers.
// Latency: none (pure functions).
// Backpressure: not applicable.
//
// Masks are passed zero-extended to TCODE_MAX_W bits. The zero padding above
// the real mask width is what keeps both functions width-agnostic. An all-ones
// mask carries into the first padding bit, so it reads as legal. The first
// padding bit is also the "lowest zero" of an all-ones mask, which gives the
// count dec_width.
package base_tcode_pkg;

    localparam int unsigned TCODE_MAX_W = 64;
    localparam int unsigned TCODE_IDX_W = 7;

    typedef logic [TCODE_MAX_W-1:0] tcode_mask_t;
    typedef logic [TCODE_IDX_W-1:0] tcode_idx_t;

    // Legal iff the set bits form one run starting at bit 0.
    function automatic logic tcode_legal(input tcode_mask_t mask);
        tcode_mask_t inc;
        inc = mask + TCODE_MAX_W'(1);
        return (mask & inc) == '0;
    endfunction

    // Index of the lowest zero bit. The scan runs top-down so that the lowest
    // zero bit is the last one to write the result.
    function automatic tcode_idx_t tcode_lowest_zero(input tcode_mask_t mask);
        tcode_idx_t idx;
        idx = tcode_idx_t'(TCODE_MAX_W);
        for (int i = TCODE_MAX_W - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                idx = tcode_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/base_tenc_le_core.sv
// Combinational thermometer mask to (count, err) conversion.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipe gates its use.
//
// Ports:
//   mask_i  - thermometer mask, dec_width bits (dec_width <= 64)
//   legal_i - legality bit, precomputed when the mask was captured
//   count_o - index of the lowest zero bit, 0..dec_width
//   err_o   - mask was not a legal thermometer code
module base_tenc_le_core
    import base_tcode_pkg::*;
#(
    parameter int unsigned dec_width = 8,
    parameter int unsigned enc_width = 4
) (
    input  logic [dec_width-1:0] mask_i,
    input  logic                 legal_i,
    output logic [enc_width-1:0] count_o,
    output logic                 err_o
);

    tcode_idx_t idx;

    // Zero-extension provides a guaranteed zero at bit dec_width.
    // An all-ones mask therefore encodes to dec_width.
    assign idx     = tcode_lowest_zero(tcode_mask_t'(mask_i));
    assign count_o = enc_width'(idx);
    assign err_o   = ~legal_i;

endmodule

// File: rtl/base_tenc_le_pipe.sv
// Two-stage thermometer encoder with a legality flag and a saturating error counter.
// Latency: 2 cycles from the input transfer cycle to o_v; one beat per cycle when o_r is held high.
// Backpressure: valid/ready; i_r falls combinationally from o_r when both stages are full.
//
// Ports:
//   clk, reset_n       - clock, synchronous active-low reset
//   i_v / i_r / i_d    - input stream, thermometer mask of dec_width bits
//   o_v / o_r / o_d    - output stream, count of enc_width bits (0..dec_width)
//   o_err              - travels with o_d; the source mask was not a legal thermometer code
//   i_clr              - synchronous clear of the error counter (wins over an increment)
//   o_errcnt           - saturating count of errored beats delivered
module base_tenc_le_pipe
    import base_tcode_pkg::*;
#(
    parameter int unsigned dec_width = 8,
    parameter int unsigned enc_width = 4,
    parameter int unsigned cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_v,
    output logic                 i_r,
    input  logic [dec_width-1:0] i_d,
    output logic                 o_v,
    input  logic                 o_r,
    output logic [enc_width-1:0] o_d,
    output logic                 o_err,
    input  logic                 i_clr,
    output logic [cnt_width-1:0] o_errcnt
);

    // Stage A: captured mask plus its legality bit.
    logic                 a_v_q, a_v_d;
    logic [dec_width-1:0] a_d_q, a_d_d;
    logic                 a_legal_q, a_legal_d;

    // Stage B: encoded count and error bit; these drive the outputs directly.
    logic                 o_v_q, o_v_d;
    logic [enc_width-1:0] o_d_q, o_d_d;
    logic                 o_err_q, o_err_d;

    logic [cnt_width-1:0] errcnt_q, errcnt_d;

    logic                 b_load;
    logic                 o_xfer;
    logic [enc_width-1:0] core_count;
    logic                 core_err;

    base_tenc_le_core #(
        .dec_width (dec_width),
        .enc_width (enc_width)
    ) u_core (
        .mask_i  (a_d_q),
        .legal_i (a_legal_q),
        .count_o (core_count),
        .err_o   (core_err)
    );

    // Stage B can take a beat when it is empty or its beat is leaving.
    assign b_load = ~o_v_q | o_r;
    // Stage A can take a beat when it is empty, or when B can take A's beat.
    assign i_r    = ~a_v_q | b_load;
    assign o_xfer = o_v_q & o_r;

    always_comb begin
        a_v_d     = a_v_q;
        a_d_d     = a_d_q;
        a_legal_d = a_legal_q;
        o_v_d     = o_v_q;
        o_d_d     = o_d_q;
        o_err_d   = o_err_q;
        errcnt_d  = errcnt_q;

        // Whenever i_r is high, A's beat (if any) moves on this edge.
        // A therefore simply takes whatever arrives, or empties.
        if (i_r) begin
            a_v_d = i_v;
            if (i_v) begin
                a_d_d     = i_d;
                a_legal_d = tcode_legal(tcode_mask_t'(i_d));
            end
        end

        // Output data only changes when a real beat lands. When B drains
        // with nothing behind it, the last delivered value stays on o_d.
        if (b_load) begin
            o_v_d = a_v_q;
            if (a_v_q) begin
                o_d_d   = core_count;
                o_err_d = core_err;
            end
        end

        if (i_clr) begin
            errcnt_d = '0;
        end else if (o_xfer && o_err_q && (errcnt_q != {cnt_width{1'b1}})) begin
            errcnt_d = errcnt_q + cnt_width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_v_q    <= 1'b0;
            o_v_q    <= 1'b0;
            o_d_q    <= '0;
            o_err_q  <= 1'b0;
            errcnt_q <= '0;
        end else begin
            a_v_q    <= a_v_d;
            o_v_q    <= o_v_d;
            o_d_q    <= o_d_d;
            o_err_q  <= o_err_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Stage-A payload is qualified by a_v_q, so it carries no reset.
    always_ff @(posedge clk) begin
        a_d_q     <= a_d_d;
        a_legal_q <= a_legal_d;
    end

    assign o_v      = o_v_q;
    assign o_d      = o_d_q;
    assign o_err    = o_err_q;
    assign o_errcnt = errcnt_q;

endmodule
